dmem_block_responder: RTL
=========================

Name: dmem_block_responder

Overview:
- Memory-side responder for the CPU data-memory interface, at the far end of MemRead/MemWrite (word access) and dBlkRead/dBlkWrite (256-bit cache-block transfer).
- Holds a word-addressed backing store. Single-word accesses complete in one cycle.
- Block transfers run through a fixed access latency, then an 8-beat internal burst, then a one-cycle done pulse.
- Used as the data-memory model under the pipelined core and its data cache.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the backing store; must be a power of 2 and at least 8.
- LATENCY, 4, idle cycles between block-request accept and first burst beat; 0 is legal.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-low reset.
- MemRead  input  1  word read request.
- MemWrite  input  1  word write request.
- dBlkRead  input  1  block read request.
- dBlkWrite  input  1  block write request.
- data_address_2DM  input  32  byte address for word and block requests.
- data_write_2DM  input  32  word write data.
- block_write_2DM  input  256  block write data; word i is bits [32i+31:32i].
- data_read_fDM  output  32  registered word read data.
- block_read_fDM  output  256  registered block read data, same word ordering as block_write_2DM.
- busy  output  1  high while a block transfer is in progress.
- done  output  1  one-cycle pulse at block completion.

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; beat and wait counters cleared.
  - data_read_fDM=0, block_read_fDM=0, busy=0, done=0.
  - Backing store is not cleared.
- Addressing:
  - Word index = data_address_2DM[1:0] dropped, taken modulo DEPTH_WORDS (wraps, no error).
  - Block base = address with [4:0] forced to 0; beat b uses word index (base+b) modulo DEPTH_WORDS.
- Requests are sampled only in IDLE. If several are high, priority is dBlkWrite > dBlkRead > MemWrite > MemRead; lower-priority requests in that cycle are dropped.
- Outside IDLE all requests are ignored. The requester holds a block request until done, then drops it. A request still high in the cycle after done is treated as a new request.
- IDLE, MemWrite: data_write_2DM is written at the edge.
- IDLE, MemRead: data_read_fDM is updated at the edge (visible the following cycle). It holds its value otherwise, including while busy.
- IDLE, block request: address and block_write_2DM are latched, and the operation type is recorded.
  - Next state is WAIT if LATENCY>0, else BURST.
  - busy=1 from the cycle after the accept edge through the DONE cycle inclusive.
- WAIT: stays exactly LATENCY cycles, counting down, then goes to BURST with beat=0.
- BURST: exactly 8 cycles, one beat per cycle (beat 0..7).
  - Write: latched word beat is stored to the array.
  - Read: array word is captured into an internal assembly buffer slot beat.
  - After beat 7, go to DONE.
- DONE: one cycle; done=1.
  - For a read, block_read_fDM is loaded from the assembly buffer at the edge entering DONE, so it is valid while done=1.
  - block_read_fDM holds until the next block read completes.
  - Next state is IDLE.
- Latency: done is high in cycle LATENCY+9 after the accept edge (cycle 13 for LATENCY=4; cycle 9 for LATENCY=0). Total busy cycles = LATENCY+9.
- Ordering: a block read issued after a block or word write to the same words returns the new data.
- Reset mid-operation: the transfer aborts immediately with no done pulse. Block-write beats already committed stay in the array; the rest are not written.

Test Plan:
- Word write/read: MemWrite addr 0x40 data 0xDEADBEEF, then MemRead addr 0x43 -> data_read_fDM=0xDEADBEEF one cycle later; busy and done stay 0.
- Block write then read, LATENCY=4: dBlkWrite addr 0x105, block words i=0x1000+i; then dBlkRead addr 0x100.
  - Both: done pulses in cycle 13 after accept; busy high 13 cycles.
  - Read: block_read_fDM word i = 0x1000+i.
  - Word read of 0x10C then returns 0x1003.
- Priority and busy-ignore:
  - MemRead, MemWrite and dBlkRead high together in IDLE -> block read only; array unchanged.
  - MemWrite pulse while busy -> array unchanged, data_read_fDM unchanged.
- Wrap: DEPTH_WORDS=8, word write to addr 0x20 -> same storage as addr 0x00 (read of 0x00 returns it).
- LATENCY=0: block read -> done in cycle 9 after accept, busy 9 cycles.
- Reset mid-burst: assert RESET low during beat 3 of a block write of all 0xFFFFFFFF over a zeroed block.
  - Outputs go 0 immediately; no done pulse.
  - After release, block read returns words 0..2 = 0xFFFFFFFF and words 3..7 = 0.

Source files
------------

// File: rtl/dmem_block_responder.sv
// dmem_block_responder
//   Memory-side model for the CPU data-memory port. Holds a word-addressed
//   backing store. Single-word reads/writes finish in one cycle; 256-bit
//   block transfers go through LATENCY wait cycles, an 8-beat burst and a
//   one-cycle done pulse.
//
// Ports
//   CLK               clock, all state changes on the rising edge
//   RESET             asynchronous, active-low reset
//   MemRead/MemWrite  word read / word write request
//   dBlkRead/dBlkWrite block read / block write request
//   data_address_2DM  byte address for word and block requests
//   data_write_2DM    word write data
//   block_write_2DM   block write data, word i = bits [32i+31:32i]
//   data_read_fDM     registered word read data
//   block_read_fDM    registered block read data, same word ordering
//   busy              high while a block transfer is in progress
//   done              one-cycle pulse in the final cycle of a block transfer
//   dbg_state         current FSM state (IDLE=0, WAIT=1, BURST=2, DONE=3)
//
// Handshake: requests are sampled only while IDLE, with priority
//   dBlkWrite > dBlkRead > MemWrite > MemRead; lower-priority requests in the
//   same cycle are dropped. Outside IDLE every request is ignored. A block
//   requester holds its request until it sees done and then drops it; a
//   request still high in the cycle after done starts a new transfer.
module dmem_block_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MemRead,
  input  logic         MemWrite,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [31:0]  data_address_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [255:0] block_write_2DM,
  output logic [31:0]  data_read_fDM,
  output logic [255:0] block_read_fDM,
  output logic         busy,
  output logic         done,
  output logic [1:0]   dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int WW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [WW-1:0]     r_wait;
  logic [2:0]        r_beat;
  logic              r_is_wr;
  logic [AW-1:0]     r_base;
  logic [7:0][31:0]  r_wdata;
  logic [7:0][31:0]  r_asm;
  logic [31:0]       r_rd_word;
  logic [255:0]      r_blk_rd;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_idle;
  logic              w_acc_bwr;
  logic              w_acc_brd;
  logic              w_word_we;
  logic              w_word_re;
  logic              w_burst_we;
  logic [AW-1:0]     w_word_idx;
  logic [AW-1:0]     w_blk_base;
  logic [AW-1:0]     w_beat_idx;
  logic [7:0][31:0]  w_asm_next;
  logic              w_unused_addr;

  assign w_idle     = (r_state == S_IDLE);
  assign w_acc_bwr  = w_idle & dBlkWrite;
  assign w_acc_brd  = w_idle & dBlkRead & ~dBlkWrite;
  assign w_word_we  = w_idle & MemWrite & ~dBlkRead & ~dBlkWrite;
  assign w_word_re  = w_idle & MemRead & ~MemWrite & ~dBlkRead & ~dBlkWrite;
  assign w_burst_we = (r_state == S_BURST) & r_is_wr;

  // Dropping the byte offset and truncating to AW bits gives the modulo wrap.
  assign w_word_idx = data_address_2DM[AW+1:2];
  assign w_blk_base = w_word_idx & ~AW'(7);
  // Base is 8-word aligned and DEPTH_WORDS >= 8, so OR-ing the beat never carries.
  assign w_beat_idx = r_base | AW'(r_beat);

  // Bits above the store size and the byte offset do not select storage.
  assign w_unused_addr = ^{data_address_2DM[31:AW+2], data_address_2DM[1:0]};

  // Assembly buffer with the current beat's word merged in, so the beat-7 word
  // lands in block_read_fDM on the same edge that enters DONE.
  always_comb begin
    w_asm_next         = r_asm;
    w_asm_next[r_beat] = r_mem[w_beat_idx];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_beat    <= '0;
      r_is_wr   <= 1'b0;
      r_base    <= '0;
      r_wdata   <= '0;
      r_asm     <= '0;
      r_rd_word <= '0;
      r_blk_rd  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_word_re) r_rd_word <= r_mem[w_word_idx];
          if (w_acc_bwr || w_acc_brd) begin
            r_is_wr <= w_acc_bwr;
            r_base  <= w_blk_base;
            r_wdata <= block_write_2DM;
            r_beat  <= '0;
            // Loaded with LATENCY-1 so the WAIT state lasts exactly LATENCY cycles.
            r_wait  <= WW'(LATENCY - 1);
            r_state <= (LATENCY > 0) ? S_WAIT : S_BURST;
          end
        end
        S_WAIT: begin
          if (r_wait == '0) begin
            r_state <= S_BURST;
            r_beat  <= '0;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        S_BURST: begin
          if (!r_is_wr) begin
            r_asm <= w_asm_next;
            if (r_beat == 3'd7) r_blk_rd <= w_asm_next;
          end
          if (r_beat == 3'd7) r_state <= S_DONE;
          r_beat <= r_beat + 3'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Backing store is never cleared. An asynchronous reset forces r_state to
  // IDLE before the next edge, so the remaining burst beats are not written.
  always_ff @(posedge CLK) begin
    if (w_word_we) begin
      r_mem[w_word_idx] <= data_write_2DM;
    end else if (w_burst_we) begin
      r_mem[w_beat_idx] <= r_wdata[r_beat];
    end
  end

  assign data_read_fDM  = r_rd_word;
  assign block_read_fDM = r_blk_rd;
  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign dbg_state      = r_state;

endmodule
